fifo_generator: RTL and testbench

Single-clock, 32-bit-wide synchronous FIFO that buffers parallel words between a producer and a serial transmitter. The transmitter (`piso`) uses it as its TX staging buffer. The producer pushes words with `wr_en` and watches `full`. The transmitter pops words with `rd_en`, gating on `empty`, and uses `almost_empty` for look-ahead.

---
 rtl/fifo_generator_if.sv | 35 +++
 rtl/fifo_generator.sv | 105 ++++++++++
 tb/tb_fifo_generator.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/fifo_generator_if.sv
// fifo_generator_if
//   Handshake bundle between a producer/consumer pair and fifo_generator.
//   Ports carried:
//     din, wr_en          - write data and write request (producer side)
//     full                - FIFO cannot accept another word
//     rd_en               - read request (consumer side)
//     dout                - registered read data
//     empty, almost_empty - occupancy is 0 / occupancy is 0 or 1
//     data_count          - number of stored words (0..2^ADDR_WIDTH)
//   Modports:
//     master - the user side (drives requests, observes status)
//     slave  - the FIFO side
interface fifo_generator_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 9
);
  logic [DATA_WIDTH-1:0] din;
  logic                  wr_en;
  logic                  full;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] dout;
  logic                  empty;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   data_count;

  modport master (
    output din, wr_en, rd_en,
    input  full, dout, empty, almost_empty, data_count
  );

  modport slave (
    input  din, wr_en, rd_en,
    output full, dout, empty, almost_empty, data_count
  );
endinterface

// File: rtl/fifo_generator.sv
// fifo_generator
//   Single-clock synchronous FIFO, 2^ADDR_WIDTH words of DATA_WIDTH bits,
//   used as the TX staging buffer in front of a serialiser.
//   Ports:
//     clk - sole clock, all state updates on its rising edge
//     rst - synchronous active-low reset
//     bus - fifo_generator_if.slave: din/wr_en/full on the write side,
//           rd_en/dout/empty/almost_empty on the read side, data_count.
//   Behaviour:
//     - writes are accepted when wr_en && !full, reads when rd_en && !empty,
//       using the registered flags of the current cycle;
//     - dout is registered and updates on the edge that accepts a read,
//       otherwise it holds its value;
//     - every status flag is registered from the next-state occupancy, so
//       flags reflect an accepted write/read on the same edge.
module fifo_generator #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 9
) (
  input  logic              clk,
  input  logic              rst,
  fifo_generator_if.slave   bus
);

  localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
  logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  empty_q, empty_d;
  logic                  almost_empty_q, almost_empty_d;
  logic                  full_q, full_d;

  logic do_wr;
  logic do_rd;

  // Accept decisions use the registered flags, so a write while full or a
  // read while empty never disturbs pointers, count or dout.
  assign do_wr = bus.wr_en && !full_q;
  assign do_rd = bus.rd_en && !empty_q;

  always_comb begin
    // NOTE: every signal written here gets a default first so no path can
    // leave it unassigned; that is what keeps this block free of latches.
    wptr_d         = wptr_q;
    rptr_d         = rptr_q;
    count_d        = count_q;
    dout_d         = dout_q;

    if (do_wr) wptr_d = wptr_q + ADDR_WIDTH'(1);
    if (do_rd) begin
      rptr_d = rptr_q + ADDR_WIDTH'(1);
      dout_d = mem[rptr_q];
    end

    // A simultaneous accepted read and write leaves occupancy unchanged.
    unique case ({do_wr, do_rd})
      2'b10:   count_d = count_q + (ADDR_WIDTH+1)'(1);
      2'b01:   count_d = count_q - (ADDR_WIDTH+1)'(1);
      default: count_d = count_q;
    endcase

    empty_d        = (count_d == '0);
    almost_empty_d = (count_d <= (ADDR_WIDTH+1)'(1));
    full_d         = (count_d == DEPTH);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!rst) begin
      wptr_q         <= '0;
      rptr_q         <= '0;
      count_q        <= '0;
      dout_q         <= '0;
      empty_q        <= 1'b1;
      almost_empty_q <= 1'b1;
      full_q         <= 1'b0;
    end else begin
      wptr_q         <= wptr_d;
      rptr_q         <= rptr_d;
      count_q        <= count_d;
      dout_q         <= dout_d;
      empty_q        <= empty_d;
      almost_empty_q <= almost_empty_d;
      full_q         <= full_d;
    end
  end

  // NOTE: the storage array has no reset; resetting the pointers makes its
  // contents unreachable, and a reset-free array maps onto RAM primitives.
  always_ff @(posedge clk) begin
    if (rst && do_wr) mem[wptr_q] <= bus.din;
  end

  assign bus.dout         = dout_q;
  assign bus.empty        = empty_q;
  assign bus.almost_empty = almost_empty_q;
  assign bus.full         = full_q;
  assign bus.data_count   = count_q;

endmodule

// File: tb/tb_fifo_generator.sv
// tb_fifo_generator
//   Directed plus randomized bench for fifo_generator. A queue-based model
//   tracks the stored words and the last word read; after every clock edge
//   all five outputs are compared against it.
module tb_fifo_generator;

  localparam int DW    = 32;
  localparam int AW    = 9;
  localparam int DEPTH = 1 << AW;

  logic clk;
  logic rst;

  fifo_generator_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  fifo_generator #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  // Reference model: FIFO contents and the word last presented on dout.
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_dout = '0;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    check("empty",        64'(bus.empty),        64'(q.size() == 0));
    check("almost_empty", 64'(bus.almost_empty), 64'(q.size() <= 1));
    check("full",         64'(bus.full),         64'(q.size() == DEPTH));
    check("data_count",   64'(bus.data_count),   64'(q.size()));
    check("dout",         64'(bus.dout),         64'(m_dout));
  endtask

  // One clock: drive inputs, advance past the edge, update model, compare.
  task automatic cycle(input logic w, input logic r, input logic [DW-1:0] d,
                       input logic rs);
    bit do_wr, do_rd;
    rst       = rs;
    bus.wr_en = w;
    bus.rd_en = r;
    bus.din   = d;
    do_wr = w && (q.size() < DEPTH);
    do_rd = r && (q.size() != 0);
    @(posedge clk);
    #1;
    if (!rs) begin
      q.delete();
      m_dout = '0;
    end else begin
      if (do_rd) m_dout = q.pop_front();
      if (do_wr) q.push_back(d);
    end
    compare_all();
  endtask

  initial begin
    rst       = 1'b0;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    bus.din   = '0;

    // Reset with both requests active.
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 32'h5555_0000 + i, 1'b0);
    check("rst_dout", 64'(bus.dout), 64'h0);

    // Ordering and one-cycle read latency.
    cycle(1'b1, 1'b0, 32'hDEADBEEF, 1'b1);
    cycle(1'b1, 1'b0, 32'h00000001, 1'b1);
    cycle(1'b1, 1'b0, 32'hA5A5A5A5, 1'b1);
    cycle(1'b0, 1'b1, '0, 1'b1);
    check("ord0", 64'(bus.dout), 64'hDEADBEEF);
    cycle(1'b0, 1'b1, '0, 1'b1);
    check("ord1", 64'(bus.dout), 64'h00000001);
    check("ord1_ae", 64'(bus.almost_empty), 64'h1);
    cycle(1'b0, 1'b1, '0, 1'b1);
    check("ord2", 64'(bus.dout), 64'hA5A5A5A5);
    check("ord2_empty", 64'(bus.empty), 64'h1);

    // Fill, overflow, drain.
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, DW'(i), 1'b1);
    check("fill_full", 64'(bus.full), 64'h1);
    check("fill_count", 64'(bus.data_count), 64'd512);
    cycle(1'b1, 1'b0, 32'hFFFFFFFF, 1'b1);
    check("ovf_count", 64'(bus.data_count), 64'd512);
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b0, 1'b1, '0, 1'b1);
      check("drain", 64'(bus.dout), 64'(i));
    end
    check("drain_empty", 64'(bus.empty), 64'h1);

    // Underflow holds dout.
    cycle(1'b1, 1'b0, 32'h12345678, 1'b1);
    cycle(1'b0, 1'b1, '0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b1, '0, 1'b1);
      check("unf_dout", 64'(bus.dout), 64'h12345678);
      check("unf_count", 64'(bus.data_count), 64'h0);
    end

    // Simultaneous read/write with 5 stored; pointers wrap repeatedly.
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 32'hBB00_0000 + i, 1'b1);
    for (int i = 0; i < 1000; i++) begin
      cycle(1'b1, 1'b1, 32'hCC00_0000 + i, 1'b1);
      check("rw_count", 64'(bus.data_count), 64'd5);
    end

    // Fill to full, then read and write together.
    for (int i = 0; i < DEPTH - 5; i++) cycle(1'b1, 1'b0, 32'hDD00_0000 + i, 1'b1);
    check("full2", 64'(bus.full), 64'h1);
    cycle(1'b1, 1'b1, 32'hEEEEEEEE, 1'b1);
    check("full_rw_count", 64'(bus.data_count), 64'd511);
    check("full_rw_full", 64'(bus.full), 64'h0);
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, '0, 1'b1);

    // Reset mid-stream.
    for (int i = 0; i < 100; i++) cycle(1'b1, 1'b0, DW'($urandom), 1'b1);
    cycle(1'b1, 1'b1, 32'h0BAD0BAD, 1'b0);
    check("mid_rst_empty", 64'(bus.empty), 64'h1);
    check("mid_rst_count", 64'(bus.data_count), 64'h0);
    cycle(1'b1, 1'b0, 32'hCAFEF00D, 1'b1);
    cycle(1'b0, 1'b1, '0, 1'b1);
    check("cafe", 64'(bus.dout), 64'hCAFEF00D);

    // Randomized traffic with biased phases and rare resets.
    for (int i = 0; i < 3000; i++) begin
      int unsigned wp;
      wp = (i / 500) % 2 == 0 ? 70 : 30;
      cycle($urandom_range(0, 99) < wp, $urandom_range(0, 99) < 50,
            DW'($urandom), !($urandom_range(0, 499) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
